// File: rtl/stim_checker_pkg.sv
// Shared definitions for the stimulus sequencer / response checker.
// Holds the FSM state encoding used by stim_checker.
package stim_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stim_vec_ram.sv
// Vector table: DEPTH entries of {a, b, exp}, one synchronous write port
// and one asynchronous read port.
module stim_vec_ram #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [3*WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [3*WIDTH-1:0]         rd_data
);

    logic [3*WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only meaningful once loaded,
    // and leaving it unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_checker.sv
// Cycle-exact stimulus sequencer and response checker: drives each table
// vector for HOLD cycles and checks the DUT result LATENCY cycles in.
module stim_checker
    import stim_checker_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 16,
    parameter int HOLD    = 2,
    parameter int LATENCY = 0,
    parameter int ERRW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_en,
    input  logic [$clog2(DEPTH)-1:0]     load_addr,
    input  logic [WIDTH-1:0]             load_a,
    input  logic [WIDTH-1:0]             load_b,
    input  logic [WIDTH-1:0]             load_exp,
    input  logic [$clog2(DEPTH+1)-1:0]   vec_count,
    input  logic                         start,
    input  logic [WIDTH-1:0]             dut_z_i,
    output logic [WIDTH-1:0]             a_o,
    output logic [WIDTH-1:0]             b_o,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ERRW-1:0]              err_count,
    output logic [$clog2(DEPTH)-1:0]     first_err_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (HOLD < 1 || LATENCY >= HOLD) begin : g_param_check
        $error("stim_checker: HOLD must be >= 1 and LATENCY < HOLD");
    end

    state_t           state;
    logic [AW-1:0]    idx;
    logic [HW-1:0]    hcnt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] exp_q;

    logic             wr_en;
    logic [AW-1:0]    rd_addr;
    logic [3*WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] rd_a, rd_b, rd_exp;
    logic [CW-1:0]    vec_clamped;
    logic             sample, mismatch, hold_end, last_vec;
    logic [ERRW-1:0]  err_next;

    stim_vec_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data ({load_a, load_b, load_exp}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign {rd_a, rd_b, rd_exp} = rd_data;

    // The read port looks one vector ahead while running so the next operands
    // are ready at the hold boundary; the current expectation lives in exp_q.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latches appear.
        wr_en       = load_en && (state != APPLY) && !start;
        rd_addr     = (state == APPLY) ? AW'(idx + AW'(1)) : '0;
        vec_clamped = (vec_count > CW'(DEPTH)) ? CW'(DEPTH) : vec_count;
        sample      = (state == APPLY) && (hcnt == HW'(LATENCY));
        mismatch    = sample && (dut_z_i != exp_q);
        hold_end    = (hcnt == HW'(HOLD - 1));
        last_vec    = ((CW'(idx) + CW'(1)) == count);
        err_next    = err_count;
        if (mismatch && (err_count != '1)) begin
            err_next = err_count + ERRW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            hcnt          <= '0;
            count         <= '0;
            exp_q         <= '0;
            a_o           <= '0;
            b_o           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count     <= '0;
                        first_err_idx <= '0;
                        if (vec_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                            idx   <= '0;
                            hcnt  <= '0;
                            count <= vec_clamped;
                            a_o   <= rd_a;
                            b_o   <= rd_b;
                            exp_q <= rd_exp;
                        end
                    end
                end
                APPLY: begin
                    err_count <= err_next;
                    if (mismatch && (err_count == '0)) begin
                        first_err_idx <= idx;
                    end
                    if (hold_end) begin
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                            a_o   <= '0;
                            b_o   <= '0;
                        end else begin
                            idx   <= idx + AW'(1);
                            hcnt  <= '0;
                            a_o   <= rd_a;
                            b_o   <= rd_b;
                            exp_q <= rd_exp;
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
